alu_cnt_dec_unit: RTL and testbench

- Small combinational/sequential utility block with three independent functions:
  - a 4-bit ALU with zero/overflow/carry flags;
  - a 3-bit down-counter advanced by a slow tick strobe;
  - a 3-to-8 one-hot decoder with enable.
- Sits beside the board-level top, driving LEDs and seven-segment status.
- All functions share one clock and one reset.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu4_core.sv | 48 ++++
 rtl/alu_cnt_dec_unit.sv | 63 ++++++
 tb/tb_alu_cnt_dec_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / counter / decoder utility block:
// datapath width and the eight ALU opcodes.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU with zero, carry and signed-overflow flags.
// Carry and overflow only carry meaning for ADD and SUB and read 0 otherwise.
module alu4_core
    import alu_pkg::*;
(
    input  logic [2:0]       fnselec,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] res,
    output logic             zero,
    output logic             overflow,
    output logic             carry
);

    logic [ALU_W:0] sum;

    // Opcode decode; SUB is a + ~b + 1 so carry=1 means "no borrow"
    always_comb begin
        sum      = '0;
        res      = '0;
        overflow = 1'b0;
        carry    = 1'b0;
        case (fnselec)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                res      = sum[ALU_W-1:0];
                carry    = sum[ALU_W];
                overflow = (a[ALU_W-1] == b[ALU_W-1]) && (res[ALU_W-1] != a[ALU_W-1]);
            end
            OP_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
                res      = sum[ALU_W-1:0];
                carry    = sum[ALU_W];
                overflow = (a[ALU_W-1] != b[ALU_W-1]) && (res[ALU_W-1] != a[ALU_W-1]);
            end
            OP_NOT: res = ~a;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SLT: res = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  res = {{(ALU_W-1){1'b0}}, (a == b)};
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);

endmodule

// File: rtl/alu_cnt_dec_unit.sv
// Board-side utility block: a 4-bit ALU, a tick-driven down-counter and a
// 3-to-8 one-hot decoder sharing one clock and one asynchronous reset.
module alu_cnt_dec_unit
    import alu_pkg::*;
#(
    parameter int                CNT_W   = 3,
    parameter logic [CNT_W-1:0]  CNT_RST = CNT_W'(7)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       alu_fnselec,
    input  logic [ALU_W-1:0] alu_a,
    input  logic [ALU_W-1:0] alu_b,
    output logic [ALU_W-1:0] alu_res,
    output logic             alu_zero,
    output logic             alu_overflow,
    output logic             alu_carry,
    input  logic             tick,
    input  logic             counter_en,
    output logic [CNT_W-1:0] dec_counter_out,
    input  logic [2:0]       x,
    input  logic             en,
    output logic [7:0]       y_dec
);

    logic [CNT_W-1:0] count;
    logic             armed;

    alu4_core u_alu (
        .fnselec  (alu_fnselec),
        .a        (alu_a),
        .b        (alu_b),
        .res      (alu_res),
        .zero     (alu_zero),
        .overflow (alu_overflow),
        .carry    (alu_carry)
    );

    // Down-counter; 'armed' stays low for the first edge after reset so a
    // tick coinciding with reset release is discarded. Wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CNT_RST;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (armed && tick && counter_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign dec_counter_out = count;

    // One-hot decoder, all zeros when disabled
    always_comb begin
        y_dec = 8'h00;
        if (en) begin
            y_dec = 8'h01 << x;
        end
    end

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// Directed self-checking bench for alu_cnt_dec_unit.
module tb_alu_cnt_dec_unit;

    logic       clk;
    logic       rst;
    logic [2:0] alu_fnselec;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;
    logic       tick;
    logic       counter_en;
    logic [2:0] dec_counter_out;
    logic [2:0] x;
    logic       en;
    logic [7:0] y_dec;

    int tests_run;
    int tests_failed;

    alu_cnt_dec_unit dut (
        .clk             (clk),
        .rst             (rst),
        .alu_fnselec     (alu_fnselec),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_res         (alu_res),
        .alu_zero        (alu_zero),
        .alu_overflow    (alu_overflow),
        .alu_carry       (alu_carry),
        .tick            (tick),
        .counter_en      (counter_en),
        .dec_counter_out (dec_counter_out),
        .x               (x),
        .en              (en),
        .y_dec           (y_dec)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // ALU vectors: op, a, b, res, zero, overflow, carry
    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       zero;
        logic       ovf;
        logic       cy;
    } alu_vec_t;

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; counter_en = 1'b0;
        alu_fnselec = 3'b000; alu_a = 4'd2; alu_b = 4'd3;
        x = 3'd0; en = 1'b0;
        #12;
        tests_run++;
        if (dec_counter_out !== 3'd7) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 7", dec_counter_out);
        end
        tests_run++;
        if (alu_res !== 4'd5) begin
            tests_failed++;
            $display("[TB] FAIL alu_during_reset: got %h expected 5", alu_res);
        end
        // tick high while reset is held must not move the counter
        tick = 1'b1; counter_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (dec_counter_out !== 3'd7) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: got %0d expected 7", dec_counter_out);
        end
    endtask

    task automatic test_alu_arith();
        alu_vec_t v [6];
        v[0] = '{3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
        v[1] = '{3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};
        v[2] = '{3'b000, 4'h5, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0};
        v[3] = '{3'b001, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
        v[4] = '{3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b1};
        v[5] = '{3'b001, 4'h6, 4'h6, 4'h0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            alu_fnselec = v[i].op; alu_a = v[i].a; alu_b = v[i].b;
            #1;
            tests_run++;
            if ({alu_res, alu_zero, alu_overflow, alu_carry} !==
                {v[i].res, v[i].zero, v[i].ovf, v[i].cy}) begin
                tests_failed++;
                $display("[TB] FAIL alu_arith[%0d]: got res=%h z=%b v=%b c=%b expected res=%h z=%b v=%b c=%b",
                         i, alu_res, alu_zero, alu_overflow, alu_carry,
                         v[i].res, v[i].zero, v[i].ovf, v[i].cy);
            end
        end
    endtask

    task automatic test_alu_logic();
        alu_vec_t v [10];
        v[0] = '{3'b010, 4'hA, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0};
        v[1] = '{3'b010, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
        v[2] = '{3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
        v[3] = '{3'b011, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0};
        v[4] = '{3'b100, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0};
        v[5] = '{3'b101, 4'h6, 4'h6, 4'h0, 1'b1, 1'b0, 1'b0};
        v[6] = '{3'b110, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
        v[7] = '{3'b110, 4'h1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
        v[8] = '{3'b111, 4'h6, 4'h6, 4'h1, 1'b0, 1'b0, 1'b0};
        v[9] = '{3'b111, 4'h6, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            alu_fnselec = v[i].op; alu_a = v[i].a; alu_b = v[i].b;
            #1;
            tests_run++;
            if ({alu_res, alu_zero, alu_overflow, alu_carry} !==
                {v[i].res, v[i].zero, v[i].ovf, v[i].cy}) begin
                tests_failed++;
                $display("[TB] FAIL alu_logic[%0d]: got res=%h z=%b v=%b c=%b expected res=%h z=%b v=%b c=%b",
                         i, alu_res, alu_zero, alu_overflow, alu_carry,
                         v[i].res, v[i].zero, v[i].ovf, v[i].cy);
            end
        end
    endtask

    task automatic test_release_tick();
        // tick present on the very first edge after reset release: ignored
        @(negedge clk);
        rst = 1'b0; tick = 1'b1; counter_en = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (dec_counter_out !== 3'd7) begin
            tests_failed++;
            $display("[TB] FAIL release_tick: got %0d expected 7", dec_counter_out);
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_count_wrap();
        logic [2:0] seq [8];
        seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tick = 1'b1; counter_en = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
            tests_run++;
            if (dec_counter_out !== seq[i]) begin
                tests_failed++;
                $display("[TB] FAIL count_step[%0d]: got %0d expected %0d", i, dec_counter_out, seq[i]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        tick = 1'b1; counter_en = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (dec_counter_out !== 3'd6) begin
            tests_failed++;
            $display("[TB] FAIL hold_setup: got %0d expected 6", dec_counter_out);
        end
        @(negedge clk);
        counter_en = 1'b0; tick = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (dec_counter_out !== 3'd6) begin
            tests_failed++;
            $display("[TB] FAIL hold_en_low: got %0d expected 6", dec_counter_out);
        end
        @(negedge clk);
        counter_en = 1'b1; tick = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (dec_counter_out !== 3'd6) begin
            tests_failed++;
            $display("[TB] FAIL hold_no_tick: got %0d expected 6", dec_counter_out);
        end
    endtask

    task automatic test_async_reset();
        // two more decrements: 6 -> 4
        @(negedge clk);
        tick = 1'b1; counter_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (dec_counter_out !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_count: got %0d expected 4", dec_counter_out);
        end
        // assert reset mid-cycle, well away from any edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (dec_counter_out !== 3'd7) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %0d expected 7", dec_counter_out);
        end
        // release with tick still high: first edge ignored, next one counts
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (dec_counter_out !== 3'd7) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_first: got %0d expected 7", dec_counter_out);
        end
        @(posedge clk); #1;
        tests_run++;
        if (dec_counter_out !== 3'd6) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_second: got %0d expected 6", dec_counter_out);
        end
        tick = 1'b0;
    endtask

    task automatic test_decoder();
        logic [7:0] onehot [8];
        onehot = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = 3'(i);
            #1;
            tests_run++;
            if (y_dec !== onehot[i]) begin
                tests_failed++;
                $display("[TB] FAIL dec_en[%0d]: got %h expected %h", i, y_dec, onehot[i]);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = 3'(i);
            #1;
            tests_run++;
            if (y_dec !== 8'h00) begin
                tests_failed++;
                $display("[TB] FAIL dec_dis[%0d]: got %h expected 00", i, y_dec);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_alu_arith();
        test_alu_logic();
        test_release_tick();
        test_count_wrap();
        test_hold();
        test_async_reset();
        test_decoder();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
